// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount as 10/5/1 coins, largest first,
// one coin per eject handshake, limited by per-denomination tube inventory.
module change_dispenser #(
    parameter logic [7:0] INIT_10 = 8'd20,
    parameter logic [7:0] INIT_5  = 8'd20,
    parameter logic [7:0] INIT_1  = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] change_amount,
    input  logic       change_valid,
    input  logic       coin_ack,
    input  logic       refill,
    output logic [7:0] coin_out,
    output logic       coin_valid,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remaining,
    output logic [7:0] cnt10,
    output logic [7:0] cnt5,
    output logic [7:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] coin_out_q, coin_out_d;
    logic       coin_valid_q, coin_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       short_q, short_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] cnt10_q, cnt10_d;
    logic [7:0] cnt5_q, cnt5_d;
    logic [7:0] cnt1_q, cnt1_d;

    // State register; reset abandons any in-flight coin and restores inventory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            coin_out_q   <= 8'd0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            remaining_q  <= 8'd0;
            cnt10_q      <= INIT_10;
            cnt5_q       <= INIT_5;
            cnt1_q       <= INIT_1;
        end else begin
            state_q      <= state_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            remaining_q  <= remaining_d;
            cnt10_q      <= cnt10_d;
            cnt5_q       <= cnt5_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        short_d      = short_q;
        remaining_d  = remaining_q;
        cnt10_d      = cnt10_q;
        cnt5_d       = cnt5_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            IDLE: begin
                if (refill) begin
                    cnt10_d = INIT_10;
                    cnt5_d  = INIT_5;
                    cnt1_d  = INIT_1;
                end
                if (change_valid) begin
                    remaining_d = change_amount;
                    short_d     = 1'b0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                // Greedy pick, falling back past empty tubes
                if (remaining_q == 8'd0) begin
                    state_d = FINISH;
                end else if (remaining_q >= 8'd10 && cnt10_q != 8'd0) begin
                    coin_out_d   = 8'd10;
                    coin_valid_d = 1'b1;
                    state_d      = PRESENT;
                end else if (remaining_q >= 8'd5 && cnt5_q != 8'd0) begin
                    coin_out_d   = 8'd5;
                    coin_valid_d = 1'b1;
                    state_d      = PRESENT;
                end else if (cnt1_q != 8'd0) begin
                    coin_out_d   = 8'd1;
                    coin_valid_d = 1'b1;
                    state_d      = PRESENT;
                end else begin
                    short_d = 1'b1;
                    state_d = FINISH;
                end
            end
            PRESENT: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - coin_out_q;
                    case (coin_out_q)
                        8'd10:   cnt10_d = cnt10_q - 8'd1;
                        8'd5:    cnt5_d  = cnt5_q - 8'd1;
                        default: cnt1_d  = cnt1_q - 8'd1;
                    endcase
                    coin_out_d   = 8'd0;
                    coin_valid_d = 1'b0;
                    state_d      = SELECT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remaining  = remaining_q;
    assign cnt10      = cnt10_q;
    assign cnt5       = cnt5_q;
    assign cnt1       = cnt1_q;

endmodule
